// File: rtl/maze_player_ctrl_if.sv
// Map-ROM query port between the player controller (master) and the shared map ROM (slave).
// wall_hit answers the query presented on the previous cycle.
interface maze_player_ctrl_if;
  logic [5:0] query_col;
  logic [5:0] query_row;
  logic       query_en;
  logic       wall_hit;

  modport master (
    output query_col,
    output query_row,
    output query_en,
    input  wall_hit
  );

  modport slave (
    input  query_col,
    input  query_row,
    input  query_en,
    output wall_hit
  );
endinterface

// File: rtl/maze_player_ctrl.sv
// Player position controller for the STAGE1 maze: key edges -> wall-checked 1-cell sprite moves.
// Optional macro MOVE_HOLD_EN: a held key auto-repeats once the repeat gap has elapsed.
module maze_player_ctrl #(
  parameter int unsigned START_X      = 1,
  parameter int unsigned START_Y      = 1,
  parameter int unsigned GOAL_X       = 36,
  parameter int unsigned MOVE_PERIOD  = 2500000,
  parameter int unsigned REPEAT_TICKS = 12500000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [3:0]         i_state,
  input  logic               i_key_up,
  input  logic               i_key_down,
  input  logic               i_key_left,
  input  logic               i_key_right,
  maze_player_ctrl_if.master io_map,
  output logic [5:0]         o_player_x,
  output logic [5:0]         o_player_y,
  output logic               o_busy,
  output logic               o_bump,
  output logic               o_goal
);

  localparam logic [3:0] Stage1 = 4'd2;
  localparam logic [5:0] MaxPos = 6'd36;
  localparam logic [5:0] StartX = 6'(START_X);
  localparam logic [5:0] StartY = 6'(START_Y);
  localparam logic [5:0] GoalX  = 6'(GOAL_X);

  typedef enum logic [2:0] {StIdle, StQuery, StWait, StDecide, StCool} fsm_e;
  typedef enum logic [1:0] {DirUp, DirDown, DirLeft, DirRight} dir_e;

  fsm_e        r_fsm;
  dir_e        r_dir;
  logic [3:0]  r_key_sync;  // {up, down, left, right}
  logic [3:0]  r_key_prev;
  logic [3:0]  r_state_prev;
  logic [1:0]  r_idx;
  logic        r_hit;
  logic [31:0] r_cnt;
  logic [5:0]  r_x;
  logic [5:0]  r_y;
  logic [5:0]  r_qcol;
  logic [5:0]  r_qrow;
  logic        r_qen;
  logic        r_busy;
  logic        r_bump;
  logic        r_goal;

  logic [3:0]  w_edge;
  logic [3:0]  w_req_keys;
  logic        w_req;
  dir_e        w_req_dir;
  logic        w_blocked;
  logic        w_in_stage;
  logic        w_entry;
  logic        w_start;
  logic        w_cool_done;
  logic [11:0] w_first_q;
  logic [11:0] w_next_q;
  logic [5:0]  w_new_x;
  logic [5:0]  w_new_y;

  // Leading-edge cell of the 4x4 sprite for query slot idx, packed as {col, row}.
  function automatic logic [11:0] q_coord(input dir_e dir, input logic [5:0] x,
                                          input logic [5:0] y, input logic [1:0] idx);
    logic [5:0] ofs;
    ofs = {4'd0, idx};
    case (dir)
      DirUp:    q_coord = {x + ofs, y - 6'd1};
      DirDown:  q_coord = {x + ofs, y + 6'd4};
      DirLeft:  q_coord = {x - 6'd1, y + ofs};
      default:  q_coord = {x + 6'd4, y + ofs};
    endcase
  endfunction

  assign w_edge      = r_key_sync & ~r_key_prev;
  assign w_in_stage  = (i_state == Stage1);
  assign w_entry     = w_in_stage && (r_state_prev != Stage1);
  assign w_req       = |w_req_keys;
  assign w_start     = w_in_stage && !w_entry && (r_fsm == StIdle) && w_req;
  assign w_cool_done = (r_cnt + 32'd1) >= 32'(MOVE_PERIOD);
  assign w_first_q   = q_coord(w_req_dir, r_x, r_y, 2'd0);
  assign w_next_q    = q_coord(r_dir, r_x, r_y, r_idx + 2'd1);

`ifdef MOVE_HOLD_EN
  localparam int unsigned MinGap    = 7 + MOVE_PERIOD;
  localparam logic [31:0] RepeatGap = 32'((REPEAT_TICKS > MinGap) ? REPEAT_TICKS : MinGap);

  // Cycles since the last accepted request; saturates so long holds stay valid.
  logic [31:0] r_rep_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || w_entry) begin
      r_rep_cnt <= '0;
    end else if (w_start) begin
      r_rep_cnt <= '0;
    end else if (r_rep_cnt != '1) begin
      r_rep_cnt <= r_rep_cnt + 32'd1;
    end
  end

  assign w_req_keys = w_edge | ((r_rep_cnt >= RepeatGap) ? r_key_sync : 4'b0000);
`else
  logic w_unused_rep;
  assign w_unused_rep = ^{32'(REPEAT_TICKS)};
  assign w_req_keys   = w_edge;
`endif

  always_comb begin
    w_req_dir = DirRight;
    if (w_req_keys[3]) begin
      w_req_dir = DirUp;
    end else if (w_req_keys[2]) begin
      w_req_dir = DirDown;
    end else if (w_req_keys[1]) begin
      w_req_dir = DirLeft;
    end
  end

  always_comb begin
    w_blocked = 1'b0;
    unique case (w_req_dir)
      DirUp:    w_blocked = (r_y == 6'd0);
      DirDown:  w_blocked = (r_y == MaxPos);
      DirLeft:  w_blocked = (r_x == 6'd0);
      DirRight: w_blocked = (r_x == MaxPos);
    endcase
  end

  always_comb begin
    w_new_x = r_x;
    w_new_y = r_y;
    unique case (r_dir)
      DirUp:    w_new_y = r_y - 6'd1;
      DirDown:  w_new_y = r_y + 6'd1;
      DirLeft:  w_new_x = r_x - 6'd1;
      DirRight: w_new_x = r_x + 6'd1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_fsm        <= StIdle;
      r_dir        <= DirUp;
      r_key_sync   <= '0;
      r_key_prev   <= '0;
      r_state_prev <= '0;
      r_idx        <= '0;
      r_hit        <= 1'b0;
      r_cnt        <= '0;
      r_x          <= StartX;
      r_y          <= StartY;
      r_qcol       <= '0;
      r_qrow       <= '0;
      r_qen        <= 1'b0;
      r_busy       <= 1'b0;
      r_bump       <= 1'b0;
      r_goal       <= 1'b0;
    end else begin
      r_key_sync   <= {i_key_up, i_key_down, i_key_left, i_key_right};
      r_key_prev   <= r_key_sync;
      r_state_prev <= i_state;
      r_bump       <= 1'b0;
      r_goal       <= 1'b0;
      if (!w_in_stage || w_entry) begin
        // Abort or stage entry: drop any move in flight without pulses.
        r_fsm  <= StIdle;
        r_idx  <= '0;
        r_hit  <= 1'b0;
        r_cnt  <= '0;
        r_qcol <= '0;
        r_qrow <= '0;
        r_qen  <= 1'b0;
        r_busy <= 1'b0;
        if (w_entry) begin
          r_x <= StartX;
          r_y <= StartY;
        end
      end else begin
        unique case (r_fsm)
          StIdle: begin
            if (w_req) begin
              r_dir  <= w_req_dir;
              r_busy <= 1'b1;
              r_idx  <= '0;
              r_hit  <= 1'b0;
              r_cnt  <= '0;
              if (w_blocked) begin
                r_fsm  <= StCool;
                r_bump <= 1'b1;
              end else begin
                r_fsm            <= StQuery;
                r_qen            <= 1'b1;
                {r_qcol, r_qrow} <= w_first_q;
              end
            end
          end
          StQuery: begin
            // The response seen during slot 0 belongs to no query of this move.
            if (r_idx != 2'd0) begin
              r_hit <= r_hit | io_map.wall_hit;
            end
            if (r_idx == 2'd3) begin
              r_fsm  <= StWait;
              r_qen  <= 1'b0;
              r_qcol <= '0;
              r_qrow <= '0;
            end else begin
              r_idx            <= r_idx + 2'd1;
              {r_qcol, r_qrow} <= w_next_q;
            end
          end
          StWait: begin
            r_hit <= r_hit | io_map.wall_hit;
            r_fsm <= StDecide;
          end
          StDecide: begin
            if (r_hit) begin
              r_bump <= 1'b1;
            end else begin
              r_x    <= w_new_x;
              r_y    <= w_new_y;
              r_goal <= (w_new_x == GoalX);
            end
            r_cnt <= '0;
            r_fsm <= StCool;
          end
          StCool: begin
            if (w_cool_done) begin
              r_fsm  <= StIdle;
              r_busy <= 1'b0;
              r_cnt  <= '0;
            end else begin
              r_cnt <= r_cnt + 32'd1;
            end
          end
          default: begin
            r_fsm  <= StIdle;
            r_busy <= 1'b0;
            r_qen  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign io_map.query_col = r_qcol;
  assign io_map.query_row = r_qrow;
  assign io_map.query_en  = r_qen;
  assign o_player_x       = r_x;
  assign o_player_y       = r_y;
  assign o_busy           = r_busy;
  assign o_bump           = r_bump;
  assign o_goal           = r_goal;

endmodule
